hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 67 ++++++
 tb/tb_hazard_scoreboard.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW hazard interlock tracking in-flight register writes between ID and WB
//   params : DEPTH (in-flight stages, sb[0]=EX .. sb[DEPTH-1]=WB), REG_AW (reg address width),
//            KILL (youngest in-flight entries dropped on flush)
//   inputs : clk, rst (sync, active high), id_valid, id_rs/id_rt + *_used, id_wr_en, id_wr_addr,
//            id_is_load, hold (freeze), flush (redirect)
//   outputs: stall (combinational), pending (any entry valid), stall_cycles (saturating count)
//   macro  : HAZARD_FWD_EN -- only a load sitting in sb[0] interlocks; all else is forwarded
module hazard_scoreboard #(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int KILL   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              hold,
  input  logic              flush,
  output logic              stall,
  output logic              pending,
  output logic [15:0]       stall_cycles
);
  logic [DEPTH-1:0]  r_valid, r_load, w_hit, w_elig;
  logic [REG_AW-1:0] r_addr [DEPTH];
  logic [15:0]       r_cnt;
  logic              w_ins, w_unused;
`ifdef HAZARD_FWD_EN
  assign w_elig = DEPTH'(r_load[0]);
`else
  assign w_elig = '1;
`endif
  assign w_unused = ^r_load;
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < DEPTH; i++)
      w_hit[i] = r_valid[i] && w_elig[i] &&
                 ((id_rs_used && id_rs != '0 && r_addr[i] == id_rs) ||
                  (id_rt_used && id_rt != '0 && r_addr[i] == id_rt));
  end
  assign stall        = id_valid && !flush && |w_hit;
  assign w_ins        = id_valid && id_wr_en && id_wr_addr != '0 && !stall && !flush;
  assign pending      = |r_valid;
  assign stall_cycles = r_cnt;
  // flush drops the KILL youngest in-flight entries as they move one stage on
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_cnt   <= '0;
    end else if (!hold) begin
      r_valid[0] <= w_ins;
      r_addr[0]  <= id_wr_addr;
      r_load[0]  <= id_is_load;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1] && !(flush && i <= KILL);
        r_addr[i]  <= r_addr[i-1];
        r_load[i]  <= r_load[i-1];
      end
      if (stall && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;
  typedef struct {
    logic       rst, v;
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu, we;
    logic [4:0] wa;
    logic       ld, hold, fl;
    logic       es, ep;
    logic [15:0] ec;
  } vec_t;
  typedef struct {
    logic        s, p;
    logic [15:0] c;
  } exp_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, hold, flush, stall, pending;
  logic [4:0] id_rs, id_rt, id_wr_addr;
  logic [15:0] stall_cycles;
  int n_vec = 0, n_bad = 0;
  vec_t vt[$];
  exp_t q[$];
  hazard_scoreboard #(.DEPTH(3), .REG_AW(5), .KILL(1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .hold(hold), .flush(flush),
    .stall(stall), .pending(pending), .stall_cycles(stall_cycles)
  );
  task automatic check(string n, logic [15:0] a, logic [15:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  function automatic vec_t mk(int r, int v, int rs, int rsu, int rt, int rtu, int we, int wa,
                              int ld, int h, int f, int es, int ep, int ec);
    vec_t x;
    x.rst = r[0]; x.v = v[0]; x.rs = 5'(rs); x.rsu = rsu[0]; x.rt = 5'(rt); x.rtu = rtu[0];
    x.we = we[0]; x.wa = 5'(wa); x.ld = ld[0]; x.hold = h[0]; x.fl = f[0];
    x.es = es[0]; x.ep = ep[0]; x.ec = 16'(ec);
    return x;
  endfunction
  task automatic apply(vec_t x);
    rst = x.rst; id_valid = x.v; id_rs = x.rs; id_rs_used = x.rsu; id_rt = x.rt;
    id_rt_used = x.rtu; id_wr_en = x.we; id_wr_addr = x.wa; id_is_load = x.ld;
    hold = x.hold; flush = x.fl;
  endtask
  task automatic run_main();
    exp_t e;
    apply(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk);
      #1;
      apply(vt[i]);
      q.push_back('{vt[i].es, vt[i].ep, vt[i].ec});
      @(negedge clk);
      e = q.pop_front();
      check($sformatf("row%0d stall", i + 1), 16'(stall), 16'(e.s));
      check($sformatf("row%0d pending", i + 1), 16'(pending), 16'(e.p));
      check($sformatf("row%0d stall_cycles", i + 1), stall_cycles, e.c);
    end
  endtask
`ifndef HAZARD_FWD_EN
  logic s_rst, s_v, s_rsu, s_we, s_stall, s_pending;
  logic [4:0] s_rs, s_wa;
  logic [15:0] s_cnt;
  hazard_scoreboard #(.DEPTH(8), .REG_AW(5), .KILL(1)) sat (
    .clk(clk), .rst(s_rst), .id_valid(s_v), .id_rs(s_rs), .id_rt(5'd0),
    .id_rs_used(s_rsu), .id_rt_used(1'b0), .id_wr_en(s_we),
    .id_wr_addr(s_wa), .id_is_load(1'b0), .hold(1'b0), .flush(1'b0),
    .stall(s_stall), .pending(s_pending), .stall_cycles(s_cnt)
  );
  task automatic sdrive(logic r, logic v, logic [4:0] rs, logic rsu, logic we, logic [4:0] wa);
    s_rst = r; s_v = v; s_rs = rs; s_rsu = rsu; s_we = we; s_wa = wa;
  endtask
  task automatic run_sat();
    sdrive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 8193; r++) begin
      sdrive(0, 1, 0, 0, 1, 5);
      @(negedge clk);
      if (r == 8191) check("sat pre-saturation count", s_cnt, 16'd65528);
      if (r == 8192) check("sat saturated count", s_cnt, 16'hFFFF);
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) begin
        sdrive(0, 1, 5, 1, 0, 0);
        @(negedge clk);
        if (r == 0 || r == 8192) check($sformatf("sat round%0d stall%0d", r, k), 16'(s_stall), 16'd1);
        @(posedge clk);
        #1;
      end
    end
    sdrive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("sat held at max", s_cnt, 16'hFFFF);
    check("sat drained pending", 16'(s_pending), 16'd0);
    @(posedge clk);
    #1;
    sdrive(0, 1, 0, 0, 1, 5);
    @(posedge clk);
    #1;
    sdrive(0, 1, 5, 1, 0, 0);
    @(negedge clk);
    check("sat pre-rst stall", 16'(s_stall), 16'd1);
    @(posedge clk);
    #1;
    sdrive(1, 1, 5, 1, 0, 0);
    @(posedge clk);
    #1;
    sdrive(0, 1, 5, 1, 0, 0);
    @(negedge clk);
    check("rst mid-stall stall", 16'(s_stall), 16'd0);
    check("rst mid-stall pending", 16'(s_pending), 16'd0);
    check("rst mid-stall count", s_cnt, 16'd0);
  endtask
`endif
  initial begin
`ifdef HAZARD_FWD_EN
    vt.push_back(mk(0,1,0,0,0,0,1,8,1,0,0, 0,0,0));
    vt.push_back(mk(0,1,0,0,8,1,1,9,0,0,0, 1,1,0));
    vt.push_back(mk(0,1,0,0,8,1,1,9,0,0,0, 0,1,1));
    vt.push_back(mk(0,1,9,1,0,0,0,0,0,0,0, 0,1,1));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,1));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,1));
    vt.push_back(mk(0,1,0,0,0,0,1,0,1,0,0, 0,0,1));
    vt.push_back(mk(0,1,0,1,0,1,0,0,0,0,0, 0,0,1));
    vt.push_back(mk(0,1,0,0,0,0,1,4,1,0,0, 0,0,1));
    vt.push_back(mk(0,1,4,1,0,0,0,0,0,1,0, 1,1,1));
    vt.push_back(mk(0,1,4,1,0,0,0,0,0,1,0, 1,1,1));
    vt.push_back(mk(0,1,4,1,0,0,0,0,0,0,0, 1,1,1));
    vt.push_back(mk(0,1,4,1,0,0,0,0,0,0,0, 0,1,2));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,2));
    vt.push_back(mk(0,1,0,0,0,0,1,10,1,0,0, 0,0,2));
    vt.push_back(mk(0,1,10,1,0,0,0,0,0,0,1, 0,1,2));
    vt.push_back(mk(0,1,10,1,0,0,0,0,0,0,0, 0,0,2));
    vt.push_back(mk(0,1,0,0,0,0,1,13,1,0,0, 0,0,2));
    vt.push_back(mk(0,1,13,1,0,0,0,0,0,0,0, 1,1,2));
    vt.push_back(mk(1,1,13,1,0,0,0,0,0,0,0, 0,1,3));
    vt.push_back(mk(0,1,13,1,0,0,0,0,0,0,0, 0,0,0));
`else
    vt.push_back(mk(0,1,0,0,0,0,1,5,0,0,0, 0,0,0));
    vt.push_back(mk(0,1,5,1,0,0,1,6,0,0,0, 1,1,0));
    vt.push_back(mk(0,1,5,1,0,0,1,6,0,0,0, 1,1,1));
    vt.push_back(mk(0,1,5,1,0,0,1,6,0,0,0, 1,1,2));
    vt.push_back(mk(0,1,5,1,0,0,1,6,0,0,0, 0,0,3));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,3));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,3));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,3));
    vt.push_back(mk(0,1,0,0,0,0,1,0,0,0,0, 0,0,3));
    vt.push_back(mk(0,1,0,1,0,1,0,0,0,0,0, 0,0,3));
    vt.push_back(mk(0,1,0,0,0,0,1,7,0,0,0, 0,0,3));
    vt.push_back(mk(0,1,7,0,7,0,0,0,0,0,0, 0,1,3));
    vt.push_back(mk(0,1,0,0,7,1,0,0,0,0,0, 1,1,3));
    vt.push_back(mk(0,1,0,0,7,1,0,0,0,0,0, 1,1,4));
    vt.push_back(mk(0,1,0,0,7,1,0,0,0,0,0, 0,0,5));
    vt.push_back(mk(0,1,0,0,0,0,1,9,0,0,0, 0,0,5));
    vt.push_back(mk(0,1,9,1,0,0,0,0,0,0,0, 1,1,5));
    for (int i = 0; i < 4; i++) vt.push_back(mk(0,1,9,1,0,0,0,0,0,1,0, 1,1,6));
    vt.push_back(mk(0,1,9,1,0,0,0,0,0,0,0, 1,1,6));
    vt.push_back(mk(0,1,9,1,0,0,0,0,0,0,0, 1,1,7));
    vt.push_back(mk(0,1,9,1,0,0,0,0,0,0,0, 0,0,8));
    vt.push_back(mk(0,1,0,0,0,0,1,10,0,0,0, 0,0,8));
    vt.push_back(mk(0,1,10,1,0,0,0,0,0,0,1, 0,1,8));
    vt.push_back(mk(0,1,10,1,0,0,0,0,0,0,0, 0,0,8));
    vt.push_back(mk(0,1,0,0,0,0,1,11,0,0,0, 0,0,8));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,8));
    vt.push_back(mk(0,1,11,1,0,0,1,12,0,0,1, 0,1,8));
    vt.push_back(mk(0,1,12,1,0,0,0,0,0,0,0, 0,1,8));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,8));
    vt.push_back(mk(0,1,0,0,0,0,1,13,0,0,0, 0,0,8));
    vt.push_back(mk(0,1,13,1,0,0,0,0,0,0,0, 1,1,8));
    vt.push_back(mk(1,1,13,1,0,0,0,0,0,0,0, 1,1,9));
    vt.push_back(mk(0,1,13,1,0,0,0,0,0,0,0, 0,0,0));
`endif
    vt.push_back(mk(0,1,0,0,0,0,1,3,0,0,0, 0,0,0));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,1,1, 0,1,0));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0));
    fork
      run_main();
`ifndef HAZARD_FWD_EN
      run_sat();
`endif
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
